// File: rtl/wr_arbiter.sv
// wr_arbiter: write-side arbiter/sequencer for the 8-entry clock-crossing buffer.
// Optional lost-word counter enabled by defining WR_ARBITER_LOSS_CNT_EN.
`default_nettype none

module wr_arbiter #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              src0_valid,
    input  logic [DATA_W-1:0] src0_data,
    output logic              src0_ready,
    input  logic              src1_valid,
    input  logic [DATA_W-1:0] src1_data,
    output logic              src1_ready,
    input  logic              buffer_full,
    output logic              data_1_en,
    output logic [DATA_W-1:0] data_1,
    output logic              stall,
    output logic              cur_src
`ifdef WR_ARBITER_LOSS_CNT_EN
    ,
    output logic [7:0]        lost_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_BLOCKED = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_en;
    logic [DATA_W-1:0]   r_data;
    logic                r_stall;
    logic                r_cur;
    logic                r_rr_last;

    logic                w_want0;
    logic                w_want1;
    logic                w_arb;
    logic                w_gnt0;
    logic                w_gnt1;

    // In round-robin a tie goes to the source that did not win last time.
    always_comb begin
        w_want0 = 1'b0;
        w_want1 = 1'b0;
        case (mode)
            2'b00: w_want0 = src0_valid;
            2'b01: w_want1 = src1_valid;
            2'b10: begin
                w_want0 = src0_valid && !(src1_valid && !r_rr_last);
                w_want1 = src1_valid && !(src0_valid &&  r_rr_last);
            end
            default: begin
                w_want0 = src0_valid;
                w_want1 = src1_valid && !src0_valid;
            end
        endcase
        w_arb  = (r_state == S_IDLE) && !buffer_full;
        w_gnt0 = w_arb && w_want0;
        w_gnt1 = w_arb && w_want1;
    end

    assign src0_ready = w_gnt0;
    assign src1_ready = w_gnt1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_en      <= 1'b0;
            r_data    <= '0;
            r_stall   <= 1'b0;
            r_cur     <= 1'b0;
            r_rr_last <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (buffer_full) begin
                        r_state <= S_BLOCKED;
                        r_stall <= 1'b1;
                    end else if (w_gnt0 || w_gnt1) begin
                        r_state   <= S_ISSUE;
                        r_en      <= 1'b1;
                        r_data    <= w_gnt1 ? src1_data : src0_data;
                        r_cur     <= w_gnt1;
                        r_rr_last <= w_gnt1;
                    end
                end
                // The strobe fires regardless of buffer_full; a full buffer drops the word.
                S_ISSUE: begin
                    r_en <= 1'b0;
                    if (buffer_full) begin
                        r_state <= S_BLOCKED;
                        r_stall <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BLOCKED: begin
                    if (!buffer_full) begin
                        r_state <= S_IDLE;
                        r_stall <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_en    <= 1'b0;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    assign data_1_en = r_en;
    assign data_1    = r_data;
    assign stall     = r_stall;
    assign cur_src   = r_cur;

`ifdef WR_ARBITER_LOSS_CNT_EN
    logic [7:0] r_lost;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lost <= 8'd0;
        end else if ((r_state == S_ISSUE) && buffer_full && (r_lost != 8'hFF)) begin
            r_lost <= r_lost + 8'd1;
        end
    end

    assign lost_cnt = r_lost;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wr_arbiter.sv
// tb_wr_arbiter: table vectors, directed corner sequences and randomized
// traffic checked against a behavioural model of wr_arbiter.
`default_nettype none

module tb_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        src0_valid = 1'b0;
    logic [15:0] src0_data = 16'h0;
    logic        src0_ready;
    logic        src1_valid = 1'b0;
    logic [15:0] src1_data = 16'h0;
    logic        src1_ready;
    logic        buffer_full = 1'b0;
    logic        data_1_en;
    logic [15:0] data_1;
    logic        stall;
    logic        cur_src;
`ifdef WR_ARBITER_LOSS_CNT_EN
    logic [7:0]  lost_cnt;
`endif

    wr_arbiter #(.DATA_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .src0_valid  (src0_valid),
        .src0_data   (src0_data),
        .src0_ready  (src0_ready),
        .src1_valid  (src1_valid),
        .src1_data   (src1_data),
        .src1_ready  (src1_ready),
        .buffer_full (buffer_full),
        .data_1_en   (data_1_en),
        .data_1      (data_1),
        .stall       (stall),
        .cur_src     (cur_src)
`ifdef WR_ARBITER_LOSS_CNT_EN
        ,
        .lost_cnt    (lost_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = waiting to arbitrate, 1 = strobe cycle, 2 = held by full buffer.
    int          m_phase;
    logic        m_en, m_cur, m_stall, m_rr;
    logic [15:0] m_d1;
    int          m_lost;

    task automatic model_reset();
        m_phase = 0; m_en = 0; m_cur = 0; m_stall = 0; m_rr = 1; m_d1 = 0; m_lost = 0;
    endtask

    task automatic model_ready(input logic [1:0] md, input logic v0, input logic v1,
                               input logic bf, output logic g0, output logic g1);
        g0 = 0;
        g1 = 0;
        if (m_phase == 0 && !bf) begin
            g0 = v0 && (md != 2'b01);
            g1 = v1 && (md != 2'b00);
            if (md == 2'b11 && v0) g1 = 0;
            if (md == 2'b10 && g0 && g1) begin
                if (m_rr) g1 = 0; else g0 = 0;
            end
        end
    endtask

    task automatic model_edge(input logic [15:0] d0, input logic [15:0] d1, input logic bf,
                              input logic g0, input logic g1);
        case (m_phase)
            0: begin
                if (bf) begin
                    m_phase = 2; m_stall = 1;
                end else if (g0 || g1) begin
                    m_phase = 1; m_en = 1; m_d1 = g1 ? d1 : d0; m_cur = g1; m_rr = g1;
                end
            end
            1: begin
                m_en = 0;
                if (bf) begin
                    m_phase = 2; m_stall = 1;
                    if (m_lost < 255) m_lost++;
                end else begin
                    m_phase = 0;
                end
            end
            default: begin
                if (!bf) begin
                    m_phase = 0; m_stall = 0;
                end
            end
        endcase
    endtask

    task automatic drive(input logic [1:0] md, input logic v0, input logic [15:0] d0,
                         input logic v1, input logic [15:0] d1, input logic bf);
        mode = md; src0_valid = v0; src0_data = d0;
        src1_valid = v1; src1_data = d1; buffer_full = bf;
    endtask

    logic        s_en;
    logic [15:0] s_d;

    // One model-checked cycle; entered and left just after a falling edge.
    task automatic step_m(input logic [1:0] md, input logic v0, input logic [15:0] d0,
                          input logic v1, input logic [15:0] d1, input logic bf,
                          output logic g0, output logic g1);
        drive(md, v0, d0, v1, d1, bf);
        #1;
        model_ready(md, v0, v1, bf, g0, g1);
        s_en = data_1_en;
        s_d  = data_1;
        chk("src0_ready", 16'(src0_ready), 16'(g0));
        chk("src1_ready", 16'(src1_ready), 16'(g1));
        chk("data_1_en",  16'(data_1_en),  16'(m_en));
        chk("data_1",     data_1,          m_d1);
        chk("cur_src",    16'(cur_src),    16'(m_cur));
        chk("stall",      16'(stall),      16'(m_stall));
`ifdef WR_ARBITER_LOSS_CNT_EN
        chk("lost_cnt",   16'(lost_cnt),   16'(m_lost));
`endif
        @(posedge clk);
        model_edge(d0, d1, bf, g0, g1);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  md;
        logic        v0;
        logic [15:0] d0;
        logic        v1;
        logic [15:0] d1;
        logic        bf;
        logic        r0, r1, en;
        logic [15:0] dq;
        logic        cur, st;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic g0, g1;
        logic [15:0] exp_rr[4];
        logic        p0v, p1v, bf;
        logic [15:0] p0d, p1d;
        logic [1:0]  rmd;
        int          k, t_prev;

        tbl[0]  = '{2'b00, 1, 16'h5, 1, 16'h9, 0,  1, 0, 0, 16'h0, 0, 0};
        tbl[1]  = '{2'b00, 1, 16'h5, 1, 16'h9, 0,  0, 0, 1, 16'h5, 0, 0};
        tbl[2]  = '{2'b00, 0, 16'h5, 1, 16'h9, 0,  0, 0, 0, 16'h5, 0, 0};
        tbl[3]  = '{2'b01, 1, 16'h5, 1, 16'h9, 0,  0, 1, 0, 16'h5, 0, 0};
        tbl[4]  = '{2'b01, 1, 16'h5, 0, 16'h9, 1,  0, 0, 1, 16'h9, 1, 0};
        tbl[5]  = '{2'b11, 1, 16'h5, 1, 16'h9, 1,  0, 0, 0, 16'h9, 1, 1};
        tbl[6]  = '{2'b11, 1, 16'h5, 1, 16'h9, 0,  0, 0, 0, 16'h9, 1, 1};
        tbl[7]  = '{2'b11, 1, 16'h5, 1, 16'h9, 0,  1, 0, 0, 16'h9, 1, 0};
        tbl[8]  = '{2'b10, 1, 16'h5, 1, 16'h9, 0,  0, 0, 1, 16'h5, 0, 0};
        tbl[9]  = '{2'b10, 1, 16'h5, 1, 16'h9, 0,  0, 1, 0, 16'h5, 0, 0};
        tbl[10] = '{2'b10, 1, 16'h5, 1, 16'h9, 0,  0, 0, 1, 16'h9, 1, 0};
        tbl[11] = '{2'b10, 1, 16'h5, 1, 16'h9, 0,  1, 0, 0, 16'h9, 1, 0};
        tbl[12] = '{2'b11, 0, 16'h5, 1, 16'h9, 0,  0, 0, 1, 16'h5, 0, 0};
        tbl[13] = '{2'b11, 0, 16'h5, 1, 16'h9, 1,  0, 0, 0, 16'h5, 0, 0};
        tbl[14] = '{2'b11, 0, 16'h5, 1, 16'h9, 0,  0, 0, 0, 16'h5, 0, 1};
        tbl[15] = '{2'b11, 0, 16'h5, 1, 16'h9, 0,  0, 1, 0, 16'h5, 0, 0};
        tbl[16] = '{2'b00, 0, 16'h5, 0, 16'h9, 0,  0, 0, 1, 16'h9, 1, 0};

        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_en",    16'(data_1_en), 16'h0);
            chk("rst_data",  data_1,         16'h0);
            chk("rst_stall", 16'(stall),     16'h0);
            chk("rst_ready", 16'({src0_ready, src1_ready}), 16'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step_m(2'b10, 0, 16'h0, 0, 16'h0, 0, g0, g1);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].md, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].bf);
            #1;
            chk($sformatf("tbl%0d_r0", i),    16'(src0_ready), 16'(tbl[i].r0));
            chk($sformatf("tbl%0d_r1", i),    16'(src1_ready), 16'(tbl[i].r1));
            chk($sformatf("tbl%0d_en", i),    16'(data_1_en),  16'(tbl[i].en));
            chk($sformatf("tbl%0d_data", i),  data_1,          tbl[i].dq);
            chk($sformatf("tbl%0d_cur", i),   16'(cur_src),    16'(tbl[i].cur));
            chk($sformatf("tbl%0d_stall", i), 16'(stall),      16'(tbl[i].st));
            model_ready(tbl[i].md, tbl[i].v0, tbl[i].v1, tbl[i].bf, g0, g1);
            @(posedge clk);
            model_edge(tbl[i].d0, tbl[i].d1, tbl[i].bf, g0, g1);
            @(negedge clk);
        end

        // Round-robin with both producers always valid: 0001, 0002, ... two cycles apart.
        exp_rr[0] = 16'h0001; exp_rr[1] = 16'h0002; exp_rr[2] = 16'h0001; exp_rr[3] = 16'h0002;
        k = 0;
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            step_m(2'b10, 1, 16'h0001, 1, 16'h0002, 0, g0, g1);
            if (s_en && k < 4) begin
                chk("rr_data", s_d, exp_rr[k]);
                if (k > 0) chk("rr_gap", 16'(i - t_prev), 16'd2);
                t_prev = i;
                k++;
            end
        end
        chk("rr_strobes", 16'(k), 16'd4);

        // Word dropped: buffer_full during the strobe cycle.
        step_m(2'b00, 1, 16'h0033, 0, 16'h0, 0, g0, g1);
        step_m(2'b00, 0, 16'h0033, 0, 16'h0, 1, g0, g1);
        step_m(2'b00, 0, 16'h0033, 0, 16'h0, 0, g0, g1);
        step_m(2'b00, 0, 16'h0033, 0, 16'h0, 0, g0, g1);

        // Asynchronous reset in the middle of a strobe cycle.
        step_m(2'b00, 1, 16'h0077, 0, 16'h0, 0, g0, g1);
        drive(2'b00, 0, 16'h0077, 0, 16'h0, 0);
        #1;
        chk("issue_en", 16'(data_1_en), 16'h1);
        rst = 1'b0;
        #1;
        chk("midrst_en",    16'(data_1_en), 16'h0);
        chk("midrst_data",  data_1,         16'h0);
        chk("midrst_cur",   16'(cur_src),   16'h0);
`ifdef WR_ARBITER_LOSS_CNT_EN
        chk("midrst_lost",  16'(lost_cnt),  16'h0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        p0v = 0; p1v = 0; p0d = 0; p1d = 0; rmd = 2'b10;
        for (int i = 0; i < 600; i++) begin
            if (i % 16 == 0) rmd = 2'($urandom_range(0, 3));
            if (!p0v && $urandom_range(0, 2) != 0) begin p0v = 1; p0d = 16'($urandom); end
            if (!p1v && $urandom_range(0, 2) != 0) begin p1v = 1; p1d = 16'($urandom); end
            bf = ($urandom_range(0, 3) == 0);
            step_m(rmd, p0v, p0d, p1v, p1d, bf, g0, g1);
            if (g0) p0v = 0;
            if (g1) p1v = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wr_arbiter.md
Name: wr_arbiter

Overview:
- Arbitration and sequencing controller for the write side of the 8-entry clock-crossing buffer.
- Shares the single write port (data_1_en / data_1) between two producers: src0 = Fibonacci, src1 = Timer.
- Sequences writes so that at most one word is ever in flight.
- Throttles both producers while the buffer reports full. Runs in the fast write-clock domain.

Parameters:
- DATA_W, 16, width of producer and buffer data words.

Ports:
- clk  in  1  write-side clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- mode  in  2  arbitration mode: 00 src0 only, 01 src1 only, 10 round-robin, 11 fixed priority to src0.
- src0_valid  in  1  src0 holds a valid word.
- src0_data  in  DATA_W  src0 word.
- src0_ready  out  1  src0 word accepted this cycle.
- src1_valid  in  1  src1 holds a valid word.
- src1_data  in  DATA_W  src1 word.
- src1_ready  out  1  src1 word accepted this cycle.
- buffer_full  in  1  full flag from the buffer.
- data_1_en  out  1  write strobe to the buffer; registered.
- data_1  out  DATA_W  write data to the buffer; registered.
- stall  out  1  high while the controller is blocked by buffer_full.
- cur_src  out  1  source of the word currently or last on data_1 (0/1).

Behaviour:
- Reset (rst=0, async) sets:
  - state=IDLE
  - data_1_en=0, data_1=0
  - src0_ready=0, src1_ready=0
  - stall=0, cur_src=0
  - rr_last=1, so src0 wins the first round-robin tie.
- Handshake:
  - A transfer occurs when srcN_valid=1 and srcN_ready=1 in the same cycle.
  - srcN_ready is combinational and asserts only for the single granted source, only in IDLE with buffer_full=0.
  - A producer holds valid and data stable until ready.
- State IDLE:
  - If buffer_full=1: go to BLOCKED, no grant.
  - Else, if an eligible source is valid: grant it, capture its data into data_1, set cur_src, go to ISSUE.
  - Else: stay in IDLE.
- State ISSUE:
  - data_1_en=1 for exactly this one cycle.
  - Next state is BLOCKED if buffer_full=1, else IDLE.
- State BLOCKED:
  - stall=1, no grants, data_1_en=0.
  - Return to IDLE on the first cycle with buffer_full=0.
- Latency: accept at edge t makes data_1_en=1 during cycle t+1; the buffer writes at edge t+2.
- Peak throughput: one word per 2 clk cycles.
- Eligibility by mode (mode is sampled only in IDLE; a change mid-ISSUE applies at the next arbitration):
  - 00: src0 only; src1 never granted.
  - 01: src1 only; src0 never granted.
  - 10 (round-robin): if both are valid, grant the source != rr_last; if one is valid, grant it. rr_last updates only on a grant.
  - 11: src0 is always preferred; src1 is granted only when src0_valid=0.
- data_1 holds its value between writes; it is not cleared after ISSUE.
- Boundaries:
  - buffer_full rising during ISSUE: the strobe still fires (the word may be lost); then go to BLOCKED.
  - Both valid in BLOCKED: nothing is granted until buffer_full=0; arbitration then proceeds as normal.
  - Reset mid-ISSUE: data_1_en drops to 0 immediately; the in-flight word is discarded.
  - buffer_full comes from the buffer's own pointers; treat it as already valid in the clk domain.

Optional Feature:
- Macro: WR_ARBITER_LOSS_CNT_EN.
- Defined:
  - Adds output port lost_cnt[7:0], reset to 0.
  - It increments by 1 at any edge where state=ISSUE and buffer_full=1, i.e. the buffer dropped the word.
  - It saturates at 255 and clears only on reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release with no valid inputs -> data_1_en=0, stall=0, both ready=0, data_1=0 for 10 cycles.
- Single write: mode=00, src0_valid=1, src0_data=16'h0005 -> src0_ready for 1 cycle; next cycle data_1_en=1 with data_1=16'h0005 and cur_src=0; src1_valid=1 is never granted.
- Round-robin: mode=10, both sources valid continuously with src0 word=16'h0001 and src1 word=16'h0002 -> data_1 sequence 0001, 0002, 0001, 0002, each strobe 2 cycles apart.
- Priority: mode=11, both valid for 6 cycles -> only src0 granted (3 strobes); drop src0_valid -> src1 granted on the next IDLE cycle.
- Backpressure: buffer_full=1 for 5 cycles while src1_valid=1 -> stall=1 and src1_ready=0 throughout; first grant occurs the cycle after buffer_full=0.
- Loss/reset: with the macro defined, force buffer_full=1 during an ISSUE cycle -> lost_cnt=1. Assert rst=0 mid-ISSUE -> data_1_en=0 immediately and lost_cnt=0.
